// File: rtl/data_bus_io.sv
// rj32 data-bus slave: word RAM plus IO window (buffered 8N1 UART TX, LEDs, cycle counter).
// Read data is registered one cycle after the address. No backpressure: pushes to a full TX FIFO are dropped and flagged.
module data_bus_io #(
  parameter int RAM_AW  = 12,
  parameter int CLK_HZ  = 25000000,
  parameter int BAUD    = 115200,
  parameter int FIFO_AW = 4
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic [13:0] A_data,
  input  logic [15:0] D_out,
  input  logic        w_en,
  output logic [15:0] D_in,
  output logic        uart_tx,
  output logic [7:0]  leds,
  output logic        tx_busy
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int BW  = $clog2(DIV);
  localparam logic [BW-1:0]    BAUD_RELOAD = BW'(DIV - 1);
  localparam logic [BW-1:0]    BAUD_ONE    = BW'(1);
  localparam logic [FIFO_AW:0] PTR_ONE     = (FIFO_AW + 1)'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [15:0]        ram_mem [0:(1 << RAM_AW) - 1];
  logic [7:0]         fifo_mem [0:(1 << FIFO_AW) - 1];

  logic [15:0]        d_in_q;
  logic [7:0]         leds_q;
  logic               ovf_q;
  logic [31:0]        cnt_q;
  logic [15:0]        shadow_q;
  logic [FIFO_AW:0]   wr_ptr_q, rd_ptr_q;

  logic [1:0]         state_q, state_d;
  logic [BW-1:0]      baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;

  logic               io_sel;
  logic [2:0]         io_reg;
  logic [RAM_AW-1:0]  ram_addr;
  logic               ram_we, push, push_ok, pop, led_we, st_rd, cyclo_rd;
  logic               fifo_empty, fifo_full;
  logic [15:0]        rdata;
  logic               unused_addr;

  assign io_sel      = A_data[13];
  assign io_reg      = A_data[2:0];
  assign ram_addr    = A_data[RAM_AW-1:0];
  assign unused_addr = ^A_data[12:3];

  assign ram_we   = w_en && !io_sel;
  assign push     = w_en && io_sel && (io_reg == 3'd0);
  assign led_we   = w_en && io_sel && (io_reg == 3'd2);
  assign st_rd    = !w_en && io_sel && (io_reg == 3'd1);
  assign cyclo_rd = !w_en && io_sel && (io_reg == 3'd3);

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {FIFO_AW{1'b0}}});
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  // The shifter pops before the push lands, so a full FIFO still accepts.
  assign push_ok    = push && (!fifo_full || pop);

  always_comb begin
    rdata = '0;
    if (!io_sel) begin
      rdata = ram_mem[ram_addr];
    end else begin
      case (io_reg)
        3'd1:    rdata = {13'b0, ovf_q, fifo_full, fifo_empty};
        3'd2:    rdata = {8'b0, leds_q};
        3'd3:    rdata = cnt_q[15:0];
        3'd4:    rdata = shadow_q;
        default: rdata = '0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          state_d = S_START;
          baud_d  = BAUD_RELOAD;
          shift_d = fifo_mem[rd_ptr_q[FIFO_AW-1:0]];
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (baud_q == '0) begin
          state_d = S_DATA;
          baud_d  = BAUD_RELOAD;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      S_DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_RELOAD;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      default: begin
        tx_d = 1'b1;
        if (baud_q == '0) begin
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      d_in_q   <= '0;
      leds_q   <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      shadow_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      d_in_q  <= rdata;
      cnt_q   <= cnt_q + 32'd1;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      if (led_we)   leds_q   <= D_out[7:0];
      if (cyclo_rd) shadow_q <= cnt_q[31:16];
      if (push && !push_ok) begin
        ovf_q <= 1'b1;
      end else if (st_rd) begin
        ovf_q <= 1'b0;
      end
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Storage arrays carry no reset; RAM read above sees the pre-write word.
  always_ff @(posedge clock) begin
    if (ram_we)  ram_mem[ram_addr] <= D_out;
    if (push_ok) fifo_mem[wr_ptr_q[FIFO_AW-1:0]] <= D_out[7:0];
  end

  assign D_in    = d_in_q;
  assign leds    = leds_q;
  assign uart_tx = tx_q;
  assign tx_busy = !fifo_empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_data_bus_io.sv
// Scoreboard bench for data_bus_io: stimulus queues expected bus responses and TX bytes,
// a bus monitor and a serial receiver pop and compare them.
module tb_data_bus_io;

  logic        clock = 1'b0;
  logic        rst_n;
  logic [13:0] A_data;
  logic [15:0] D_out;
  logic        w_en;
  logic [15:0] D_in;
  logic        uart_tx;
  logic [7:0]  leds;
  logic        tx_busy;

  always #5 clock = ~clock;

  data_bus_io #(
    .RAM_AW (12),
    .CLK_HZ (400),
    .BAUD   (100),
    .FIFO_AW(4)
  ) dut (
    .clock  (clock),
    .rst_n  (rst_n),
    .A_data (A_data),
    .D_out  (D_out),
    .w_en   (w_en),
    .D_in   (D_in),
    .uart_tx(uart_tx),
    .leds   (leds),
    .tx_busy(tx_busy)
  );

  typedef struct packed {
    logic        cd;
    logic [15:0] d;
    logic        cb;
    logic        b;
    logic        ct;
    logic        t;
    logic        cl;
    logic [7:0]  l;
  } exp_t;

  exp_t       sb_q[$];
  string      nm_q[$];
  logic [7:0] tx_exp_q[$];

  int          n_chk = 0;
  int          n_err = 0;
  int          rx_cnt = 0;
  int          rx_ph = -1;
  logic [7:0]  rx_byte;
  logic [31:0] model_cnt;
  exp_t        m_e;
  string       m_nm;
  logic [9:0]  frame_v;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic cd, input logic [15:0] d, input logic cb, input logic b,
                              input logic ct, input logic t, input logic cl, input logic [7:0] l);
    exp_t e;
    e.cd = cd; e.d = d; e.cb = cb; e.b = b; e.ct = ct; e.t = t; e.cl = cl; e.l = l;
    return e;
  endfunction

  task automatic cyc(input string nm, input logic [13:0] a, input logic [15:0] d,
                     input logic we, input exp_t e);
    @(negedge clock);
    A_data = a;
    D_out  = d;
    w_en   = we;
    sb_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) model_cnt <= '0;
    else        model_cnt <= model_cnt + 32'd1;
  end

  // Bus monitor: each entry describes the outputs just after the edge that closes its cycle.
  always @(posedge clock) begin
    #1;
    if (sb_q.size() > 0) begin
      m_e  = sb_q.pop_front();
      m_nm = nm_q.pop_front();
      if (m_e.cd) chk({m_nm, ".D_in"},    {16'b0, D_in},    {16'b0, m_e.d});
      if (m_e.cb) chk({m_nm, ".tx_busy"}, {31'b0, tx_busy}, {31'b0, m_e.b});
      if (m_e.ct) chk({m_nm, ".uart_tx"}, {31'b0, uart_tx}, {31'b0, m_e.t});
      if (m_e.cl) chk({m_nm, ".leds"},    {24'b0, leds},    {24'b0, m_e.l});
    end
  end

  // Serial receiver, 4 clocks per bit, samples one clock into each bit.
  always @(negedge clock) begin
    if (!rst_n) begin
      rx_ph = -1;
    end else if (rx_ph < 0) begin
      if (uart_tx == 1'b0) rx_ph = 0;
    end else begin
      rx_ph++;
      if (rx_ph == 1) begin
        chk("rx_start", {31'b0, uart_tx}, 32'd0);
      end else if (rx_ph >= 5 && rx_ph <= 33 && ((rx_ph - 5) % 4) == 0) begin
        rx_byte[(rx_ph - 5) / 4] = uart_tx;
      end else if (rx_ph == 37) begin
        chk("rx_stop", {31'b0, uart_tx}, 32'd1);
        rx_cnt++;
        if (tx_exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL rx_byte: got %h expected no byte", rx_byte);
        end else begin
          chk("rx_byte", {24'b0, rx_byte}, {24'b0, tx_exp_q.pop_front()});
        end
        rx_ph = -1;
      end
    end
  end

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: simulation still running at %0t, limit reached", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    rst_n  = 1'b0;
    A_data = 14'h2005;
    D_out  = 16'h0000;
    w_en   = 1'b0;
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    #1;
    chk("init_D_in",    {16'b0, D_in},    32'd0);
    chk("init_leds",    {24'b0, leds},    32'd0);
    chk("init_uart_tx", {31'b0, uart_tx}, 32'd1);
    chk("init_tx_busy", {31'b0, tx_busy}, 32'd0);

    // Reset mid-frame with LEDs set and D_in non-zero.
    cyc("led_pre", 14'h2002, 16'h005A, 1'b1, mk(0, 16'h0, 0, 0, 0, 0, 1, 8'h5A));
    cyc("led_rd",  14'h2002, 16'h0000, 1'b0, mk(1, 16'h005A, 0, 0, 0, 0, 0, 8'h0));
    cyc("tx_pre",  14'h2000, 16'h0041, 1'b1, mk(1, 16'h0000, 1, 1, 0, 0, 0, 8'h0));
    for (int i = 0; i < 10; i++)
      cyc("tx_pre_run", 14'h2002, 16'h0000, 1'b0, mk(1, 16'h005A, 1, 1, (i == 9), 0, 0, 8'h0));
    @(posedge clock);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_D_in",    {16'b0, D_in},    32'd0);
    chk("rst_leds",    {24'b0, leds},    32'd0);
    chk("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
    chk("rst_tx_busy", {31'b0, tx_busy}, 32'd0);
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    cyc("rst_status", 14'h2001, 16'h0000, 1'b0, mk(1, 16'h0001, 1, 0, 1, 1, 1, 8'h00));

    // RAM read-first and mirror.
    cyc("ram_init",   14'h0123, 16'h1111, 1'b1, mk(0, 16'h0, 0, 0, 0, 0, 0, 8'h0));
    cyc("ram_wr",     14'h0123, 16'hBEEF, 1'b1, mk(1, 16'h1111, 0, 0, 0, 0, 0, 8'h0));
    cyc("ram_rd",     14'h0123, 16'h0000, 1'b0, mk(1, 16'hBEEF, 0, 0, 0, 0, 0, 8'h0));
    cyc("ram_mirror", 14'h1123, 16'h0000, 1'b0, mk(1, 16'hBEEF, 0, 0, 0, 0, 0, 8'h0));

    cyc("leds_wr", 14'h2002, 16'h12A5, 1'b1, mk(0, 16'h0, 0, 0, 0, 0, 1, 8'hA5));
    cyc("leds_rd", 14'h3FFA, 16'h0000, 1'b0, mk(1, 16'h00A5, 0, 0, 0, 0, 1, 8'hA5));

    // Single frame of 0x55, level per clock.
    cyc("uart_wr", 14'h2000, 16'h0055, 1'b1, mk(1, 16'h0000, 1, 1, 1, 1, 0, 8'h0));
    tx_exp_q.push_back(8'h55);
    frame_v = 10'b1010101010;
    for (int k = 0; k < 40; k++)
      cyc("uart_bit", 14'h2005, 16'h0000, 1'b0, mk(0, 16'h0, 1, 1, 1, frame_v[k / 4], 0, 8'h0));
    cyc("uart_done", 14'h2005, 16'h0000, 1'b0, mk(0, 16'h0, 1, 0, 1, 1, 0, 8'h0));

    // Overflow: 0x00 goes to the shifter, 0x01..0x10 fill the FIFO, 0x11 drops.
    for (int i = 0; i < 18; i++) begin
      cyc("ovf_push", 14'h2000, 16'(i), 1'b1, mk(1, 16'h0000, 1, 1, 0, 0, 0, 8'h0));
      if (i < 17) tx_exp_q.push_back(8'(i));
    end
    cyc("ovf_st_wr", 14'h2001, 16'hFFFF, 1'b1, mk(1, 16'h0006, 0, 0, 0, 0, 0, 8'h0));
    cyc("ovf_st1",   14'h2001, 16'h0000, 1'b0, mk(1, 16'h0006, 0, 0, 0, 0, 0, 8'h0));
    cyc("ovf_st2",   14'h2001, 16'h0000, 1'b0, mk(1, 16'h0002, 0, 0, 0, 0, 0, 8'h0));
    cyc("nop",       14'h2005, 16'h0000, 1'b0, mk(0, 16'h0, 0, 0, 0, 0, 0, 8'h0));
    waited = 0;
    while ((tx_busy || rx_ph >= 0) && waited < 2000) begin
      @(negedge clock);
      waited++;
    end
    if (waited >= 2000) begin
      n_chk++;
      n_err++;
      $display("FAIL tx_drain: still busy after %0d cycles, required idle", waited);
    end
    repeat (5) @(negedge clock);
    chk("rx_count",   rx_cnt,          32'd18);
    chk("tx_exp_left", tx_exp_q.size(), 32'd0);

    // Counter latch at 0x0001_0005.
    while (model_cnt < 32'h0001_0004) @(negedge clock);
    cyc("cyclo",  14'h2003, 16'h0000, 1'b0, mk(1, 16'h0005, 0, 0, 0, 0, 0, 8'h0));
    cyc("cychi",  14'h2004, 16'h0000, 1'b0, mk(1, 16'h0001, 0, 0, 0, 0, 0, 8'h0));
    for (int i = 0; i < 3; i++)
      cyc("nop", 14'h2005, 16'h0000, 1'b0, mk(1, 16'h0000, 0, 0, 0, 0, 0, 8'h0));
    cyc("cychi2", 14'h2004, 16'h0000, 1'b0, mk(1, 16'h0001, 0, 0, 0, 0, 1, 8'hA5));
    @(posedge clock);
    #2;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/data_bus_io.md
Name: data_bus_io

Overview:
- Data-side memory and I/O slave for the rj32 CPU, sitting directly on the CPU data bus (A_data, D_out, w_en, D_in).
- Decodes a 14-bit word address into two regions:
  - a single-port data RAM;
  - a small register window with a buffered 8N1 UART transmitter, an LED register and a free-running cycle counter.
- Returns read data to the CPU one cycle after the address is presented.

Parameters:
- RAM_AW, 12, data RAM address width (2^RAM_AW 16-bit words, mirrored across the RAM region)
- CLK_HZ, 25000000, clock frequency in Hz
- BAUD, 115200, UART bit rate; divider DIV = CLK_HZ/BAUD (integer, truncated, must be >= 2)
- FIFO_AW, 4, TX FIFO address width (depth 2^FIFO_AW bytes)

Ports:
- clock, input, 1, CPU clock; all state changes on its rising edge
- rst_n, input, 1, asynchronous active-low reset
- A_data, input, 14, word address from the CPU
- D_out, input, 16, write data from the CPU
- w_en, input, 1, write strobe; qualifies A_data/D_out in the same cycle
- D_in, output, 16, registered read data to the CPU
- uart_tx, output, 1, serial output, idle high
- leds, output, 8, LED register contents
- tx_busy, output, 1, high while the FIFO is non-empty or the shifter is active

Behaviour:
- Reset (async assert, sync release) drives outputs and state as follows:
  - D_in=0, uart_tx=1, leds=0, tx_busy=0;
  - FIFO empty, overflow flag=0, cycle counter=0, UART state IDLE.
- RAM contents are not reset.
- Decode, all data in 16-bit words:
  - A_data[13]=0 selects RAM at word A_data[RAM_AW-1:0].
  - A_data[13]=1 selects IO registers by A_data[2:0]; the remaining bits are ignored and the window mirrors.
- IO registers:
  - 0 TXDATA:
    - write pushes D_out[7:0];
    - read returns 0.
  - 1 STATUS:
    - read returns {13'b0, overflow, fifo_full, fifo_empty};
    - reading clears overflow;
    - writes are ignored.
  - 2 LEDS:
    - write sets leds = D_out[7:0];
    - read returns {8'b0, leds}.
  - 3 CYCLO:
    - read returns counter[15:0] and latches counter[31:16] into a shadow register in the same cycle;
    - writes are ignored.
  - 4 CYCHI:
    - read returns the shadow register.
  - 5..7: read 0, writes ignored.
- Read timing:
  - Every cycle, D_in is updated at the next edge with the data for the A_data present in the current cycle. Reads are implicit and unqualified.
  - RAM is read-first: a write cycle returns the old word on D_in, then stores D_out.
  - Read side effects (overflow clear, shadow latch) fire only when w_en=0.
- Cycle counter: 32-bit, increments every cycle, wraps 0xFFFFFFFF->0.
- TX FIFO:
  - Circular buffer with FIFO_AW+1-bit pointers.
  - Full when pointers differ only in the MSB; empty when they are equal.
  - A push while full is dropped and sets overflow (sticky).
  - A push and a pop in the same cycle are both performed. When full, the pop happens first and the push is accepted.
  - A push while empty is visible to the UART the next cycle.
- UART FSM, with baud counter reloading DIV-1 and each state lasting DIV cycles:
  - IDLE: uart_tx=1. If the FIFO is non-empty, pop the byte into the shifter and go to START.
  - START: uart_tx=0, then DATA.
  - DATA: send bits LSB first, 8 bits with bit index 0..7, then STOP.
  - STOP: uart_tx=1, then IDLE.
  - IDLE→START takes one cycle, so back-to-back bytes have one extra idle-high cycle between the STOP bit and the next START bit.
  - uart_tx is registered, so there are no glitches.
- tx_busy = !fifo_empty || state!=IDLE.
- Reset asserted mid-frame aborts the frame: uart_tx returns to 1 immediately and the FIFO contents are discarded.

Test Plan:
- Reset value check: assert rst_n=0 mid-run, then release. Required response:
  - D_in=0, leds=0, uart_tx=1, tx_busy=0;
  - STATUS read returns 0x0001.
- RAM write/read: write 0xBEEF to 0x0123 with RAM_AW=12, then read 0x0123 and 0x1123 (mirror). Required response:
  - D_in=0xBEEF one cycle after each address;
  - in the write cycle itself, D_in shows the prior word.
- UART frame: use DIV=4 and write 0x0055 to 0x2000. Required response:
  - the next cycle, tx_busy=1;
  - uart_tx produces 0 (start), then 1,0,1,0,1,0,1,0, then 1 (stop), each level held exactly 4 cycles;
  - tx_busy=0 after STOP.
- FIFO overflow: hold the UART busy and push 18 bytes (0x00..0x11) with depth 16. Required response:
  - STATUS reads 0x0006 (overflow, full);
  - a second STATUS read returns 0x0002;
  - the line transmits exactly 17 bytes, 0x00..0x10. One byte is popped into the shifter before the FIFO fills, so 0x11 is the dropped byte.
- Counter latch: preload by running 0x1_0000 + 5 cycles, read 0x2003 then 0x2004. Required response:
  - D_in gives the low half first, then 0x0001, even though the counter keeps incrementing between the two reads;
  - LEDS write 0x12A5 sets leds=0xA5.
